// File: rtl/bwn_fc_engine.sv
// Binary-weight fully-connected layer engine.
// Serial activations are accumulated into CLASS_NUM parallel sign-accumulators,
// biased, saturated, then either streamed out through a per-class BN (A*x+B)
// with optional ReLU, or reduced to a single argmax class index.
module bwn_fc_engine #(
    parameter int CLASS_NUM  = 120,
    parameter int INPUT_SIZE = 1274,
    parameter int D_WL       = 16,
    parameter int FL         = 8,
    parameter int ACC_WL     = 28,
    parameter int MODE       = 0,
    localparam int IN_AW     = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1,
    localparam int CLS_AW    = (CLASS_NUM > 1) ? $clog2(CLASS_NUM) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [D_WL-1:0]      in_data,
    output logic [IN_AW-1:0]            w_addr,
    input  logic [CLASS_NUM-1:0]        w_row,
    input  logic [CLASS_NUM*D_WL-1:0]   f_b,
    output logic [CLS_AW-1:0]           bn_addr,
    input  logic signed [D_WL-1:0]      bn_a,
    input  logic signed [D_WL-1:0]      bn_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [D_WL-1:0]             out_data,
    output logic                        out_last
);

    typedef enum logic [2:0] {
        S_ACCUM,
        S_BIAS,
        S_DRAIN,
        S_SCAN,
        S_RESULT
    } state_e;

    localparam int P_W = 2 * D_WL + 1;

    localparam logic [IN_AW-1:0]         IN_LAST  = IN_AW'(INPUT_SIZE - 1);
    localparam logic [CLS_AW-1:0]        CLS_LAST = CLS_AW'(CLASS_NUM - 1);
    localparam logic signed [D_WL-1:0]   D_SMAX   = {1'b0, {(D_WL-1){1'b1}}};
    localparam logic signed [D_WL-1:0]   D_SMIN   = {1'b1, {(D_WL-1){1'b0}}};
    localparam logic signed [ACC_WL-1:0] ACC_SMAX = ACC_WL'(D_SMAX);
    localparam logic signed [ACC_WL-1:0] ACC_SMIN = ACC_WL'(D_SMIN);
    localparam logic signed [P_W-1:0]    P_SMAX   = P_W'(D_SMAX);
    localparam logic signed [P_W-1:0]    P_SMIN   = P_W'(D_SMIN);

    // Clamp an accumulator value into the signed data range.
    function automatic logic signed [D_WL-1:0] satAcc(input logic signed [ACC_WL-1:0] x);
        if (x > ACC_SMAX) begin
            return D_SMAX;
        end else if (x < ACC_SMIN) begin
            return D_SMIN;
        end else begin
            return D_WL'(x);
        end
    endfunction

    // Clamp a BN result into the signed data range.
    function automatic logic signed [D_WL-1:0] satP(input logic signed [P_W-1:0] x);
        if (x > P_SMAX) begin
            return D_SMAX;
        end else if (x < P_SMIN) begin
            return D_SMIN;
        end else begin
            return D_WL'(x);
        end
    endfunction

    state_e                     state_q, state_d;
    logic [IN_AW-1:0]           inIdx_q, inIdx_d;
    logic [CLS_AW-1:0]          outIdx_q, outIdx_d;
    logic signed [ACC_WL-1:0]   acc_q [CLASS_NUM];
    logic signed [ACC_WL-1:0]   acc_d [CLASS_NUM];
    logic signed [D_WL-1:0]     maxVal_q, maxVal_d;
    logic [CLS_AW-1:0]          maxIdx_q, maxIdx_d;

    logic signed [ACC_WL-1:0]   inExt;
    logic signed [D_WL-1:0]     sSel;
    logic signed [2*D_WL-1:0]   prod;
    logic signed [2*D_WL-1:0]   prodShift;
    logic signed [P_W-1:0]      pSum;
    logic signed [D_WL-1:0]     pSat;
    logic [D_WL-1:0]            drainData;

    // Saturated class value for the class currently addressed by the output index.
    assign inExt     = ACC_WL'(in_data);
    assign sSel      = satAcc(acc_q[outIdx_q]);
    assign prod      = (2*D_WL)'(bn_a) * (2*D_WL)'(sSel);
    assign prodShift = prod >>> FL;
    assign pSum      = P_W'(prodShift) + P_W'(bn_b);
    assign pSat      = satP(pSum);
    assign drainData = ((MODE == 0) && pSat[D_WL-1]) ? '0 : pSat;

    // State, index, accumulator and argmax registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_ACCUM;
            inIdx_q  <= '0;
            outIdx_q <= '0;
            maxVal_q <= '0;
            maxIdx_q <= '0;
            for (int k = 0; k < CLASS_NUM; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            inIdx_q  <= inIdx_d;
            outIdx_q <= outIdx_d;
            maxVal_q <= maxVal_d;
            maxIdx_q <= maxIdx_d;
            for (int k = 0; k < CLASS_NUM; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

    // Next-state logic: accumulate, bias, then drain the BN stream or scan for the argmax.
    always_comb begin
        state_d  = state_q;
        inIdx_d  = inIdx_q;
        outIdx_d = outIdx_q;
        maxVal_d = maxVal_q;
        maxIdx_d = maxIdx_q;
        for (int k = 0; k < CLASS_NUM; k++) begin
            acc_d[k] = acc_q[k];
        end

        case (state_q)
            S_ACCUM: begin
                if (in_valid) begin
                    for (int k = 0; k < CLASS_NUM; k++) begin
                        acc_d[k] = w_row[k] ? (acc_q[k] + inExt) : (acc_q[k] - inExt);
                    end
                    if (inIdx_q == IN_LAST) begin
                        inIdx_d = '0;
                        state_d = S_BIAS;
                    end else begin
                        inIdx_d = inIdx_q + 1'b1;
                    end
                end
            end
            S_BIAS: begin
                for (int k = 0; k < CLASS_NUM; k++) begin
                    acc_d[k] = acc_q[k] + ACC_WL'($signed(f_b[k*D_WL +: D_WL]));
                end
                outIdx_d = '0;
                if (MODE == 2) begin
                    state_d = S_SCAN;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (outIdx_q == CLS_LAST) begin
                        outIdx_d = '0;
                        state_d  = S_ACCUM;
                        for (int k = 0; k < CLASS_NUM; k++) begin
                            acc_d[k] = '0;
                        end
                    end else begin
                        outIdx_d = outIdx_q + 1'b1;
                    end
                end
            end
            S_SCAN: begin
                if ((outIdx_q == '0) || (sSel > maxVal_q)) begin
                    maxVal_d = sSel;
                    maxIdx_d = outIdx_q;
                end
                if (outIdx_q == CLS_LAST) begin
                    outIdx_d = '0;
                    state_d  = S_RESULT;
                end else begin
                    outIdx_d = outIdx_q + 1'b1;
                end
            end
            S_RESULT: begin
                if (out_ready) begin
                    state_d = S_ACCUM;
                    for (int k = 0; k < CLASS_NUM; k++) begin
                        acc_d[k] = '0;
                    end
                end
            end
            default: begin
                state_d = S_ACCUM;
            end
        endcase
    end

    // Handshake, ROM addresses and output beat derived from the current state.
    always_comb begin
        in_ready  = (state_q == S_ACCUM);
        w_addr    = inIdx_q;
        bn_addr   = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        if (state_q == S_DRAIN) begin
            bn_addr   = outIdx_q;
            out_valid = 1'b1;
            out_last  = (outIdx_q == CLS_LAST);
            out_data  = drainData;
        end else if (state_q == S_RESULT) begin
            out_valid = 1'b1;
            out_last  = 1'b1;
            out_data  = D_WL'(maxIdx_q);
        end
    end

endmodule

// File: tb/tb_bwn_fc_engine.sv
// Testbench for bwn_fc_engine: one instance per MODE fed from a shared
// stimulus, table of directed frames plus backpressure and mid-frame reset.
module tb_bwn_fc_engine;

   localparam int CN  = 3;
   localparam int IS  = 4;
   localparam int DW  = 16;
   localparam int NV  = 10;

   typedef struct {
      logic [15:0]          inData;
      logic [0:3][2:0]      wRow;
      logic [47:0]          fB;
      logic [15:0]          bnA;
      logic [15:0]          bnB;
      logic [0:2][15:0]     exp0;
      logic [0:2][15:0]     exp1;
      logic [15:0]          exp2;
   } vec_t;

   logic                  clk;
   logic                  rst_n;
   logic                  inValid;
   logic signed [DW-1:0]  inData;
   logic [CN-1:0]         wRow;
   logic [CN*DW-1:0]      fB;
   logic signed [DW-1:0]  bnA;
   logic signed [DW-1:0]  bnB;
   logic                  outReady [3];

   logic                  inReady  [3];
   logic [1:0]            wAddr    [3];
   logic [1:0]            bnAddr   [3];
   logic                  outValid [3];
   logic [DW-1:0]         outData  [3];
   logic                  outLast  [3];

   int vectorsApplied = 0;
   int miscompares    = 0;

   vec_t vecs [NV];

   // One engine per output mode, all sharing the same input side.
   for (genvar m = 0; m < 3; m++) begin : gDut
      bwn_fc_engine #(
         .CLASS_NUM (CN),
         .INPUT_SIZE(IS),
         .D_WL      (DW),
         .FL        (8),
         .ACC_WL    (20),
         .MODE      (m)
      ) dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_valid (inValid),
         .in_ready (inReady[m]),
         .in_data  (inData),
         .w_addr   (wAddr[m]),
         .w_row    (wRow),
         .f_b      (fB),
         .bn_addr  (bnAddr[m]),
         .bn_a     (bnA),
         .bn_b     (bnB),
         .out_valid(outValid[m]),
         .out_ready(outReady[m]),
         .out_data (outData[m]),
         .out_last (outLast[m])
      );
   end

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the design never finishes a handshake.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectorsApplied++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Wait until every engine is idle, then push one frame of INPUT_SIZE beats.
   task automatic applyStimulus(input int vi, input vec_t v);
      int w;
      w = 0;
      while (!(inReady[0] && inReady[1] && inReady[2]) && w < 50) begin
         @(negedge clk);
         w++;
      end
      checkOutput($sformatf("v%0d all ready", vi), {29'd0, inReady[2], inReady[1], inReady[0]}, 32'd7);
      fB  = v.fB;
      bnA = v.bnA;
      bnB = v.bnB;
      for (int b = 0; b < IS; b++) begin
         inValid = 1'b1;
         inData  = v.inData;
         wRow    = v.wRow[b];
         #1;
         checkOutput($sformatf("v%0d beat%0d w_addr", vi, b), wAddr[1], b);
         @(negedge clk);
      end
      inValid = 1'b0;
   endtask

   // Collect the output beats of all three engines; optionally stall the BN streams after the first beat.
   task automatic collectFrame(input int vi, input vec_t v, input int stallCycles);
      int got [3];
      int n;
      int stall;
      bit inStall;
      got   = '{0, 0, 0};
      n     = 1;
      stall = 0;
      while ((got[0] < CN || got[1] < CN || got[2] < 1) && n <= 40) begin
         inStall = (stallCycles > 0) && (got[1] == 1) && (stall < stallCycles);
         if (inStall) begin
            outReady[0] = 1'b0;
            outReady[1] = 1'b0;
            inValid     = 1'b1;
            inData      = 16'sh7FFF;
            wRow        = '1;
            stall++;
         end else begin
            outReady[0] = 1'b1;
            outReady[1] = 1'b1;
            inValid     = 1'b0;
         end
         #1;
         if (inStall) begin
            checkOutput($sformatf("v%0d stall%0d data", vi, stall), outData[1], v.exp1[1]);
            checkOutput($sformatf("v%0d stall%0d bn_addr", vi, stall), bnAddr[1], 1);
            checkOutput($sformatf("v%0d stall%0d in_ready", vi, stall), {inReady[1], inReady[0]}, 0);
            checkOutput($sformatf("v%0d stall%0d valid", vi, stall), outValid[1], 1);
         end
         for (int m = 0; m < 3; m++) begin
            if (outValid[m] && outReady[m] && got[m] < ((m == 2) ? 1 : CN)) begin
               if (got[m] == 0) begin
                  checkOutput($sformatf("v%0d m%0d latency", vi, m), n, (m == 2) ? (CN + 2) : 2);
               end
               if (m == 2) begin
                  checkOutput($sformatf("v%0d m2 index", vi), outData[2], v.exp2);
                  checkOutput($sformatf("v%0d m2 last", vi), outLast[2], 1);
               end else begin
                  checkOutput($sformatf("v%0d m%0d beat%0d data", vi, m, got[m]), outData[m],
                              (m == 0) ? v.exp0[got[m]] : v.exp1[got[m]]);
                  checkOutput($sformatf("v%0d m%0d beat%0d last", vi, m, got[m]), outLast[m],
                              (got[m] == CN - 1) ? 1 : 0);
                  checkOutput($sformatf("v%0d m%0d beat%0d bn_addr", vi, m, got[m]), bnAddr[m], got[m]);
               end
               got[m]++;
            end
         end
         @(negedge clk);
         n++;
      end
      checkOutput($sformatf("v%0d m0 beat count", vi), got[0], CN);
      checkOutput($sformatf("v%0d m1 beat count", vi), got[1], CN);
      checkOutput($sformatf("v%0d m2 beat count", vi), got[2], 1);
      outReady[0] = 1'b1;
      outReady[1] = 1'b1;
      inValid     = 1'b0;
   endtask

   // Directed frames, backpressure and reset sequences.
   initial begin
      vecs[0] = '{inData: 16'h0100, wRow: {3'b111, 3'b111, 3'b011, 3'b001}, fB: 48'h0,
                  bnA: 16'h0100, bnB: 16'h0000,
                  exp0: {16'h0400, 16'h0200, 16'h0000}, exp1: {16'h0400, 16'h0200, 16'h0000}, exp2: 16'd0};
      vecs[1] = '{inData: 16'h0100, wRow: {3'b000, 3'b000, 3'b000, 3'b000}, fB: 48'h0,
                  bnA: 16'h0100, bnB: 16'h0000,
                  exp0: {16'h0000, 16'h0000, 16'h0000}, exp1: {16'hFC00, 16'hFC00, 16'hFC00}, exp2: 16'd0};
      vecs[2] = '{inData: 16'h0040, wRow: {3'b111, 3'b111, 3'b111, 3'b111}, fB: 48'h0,
                  bnA: 16'h0200, bnB: 16'h0080,
                  exp0: {16'h0280, 16'h0280, 16'h0280}, exp1: {16'h0280, 16'h0280, 16'h0280}, exp2: 16'd0};
      vecs[3] = '{inData: 16'h7FFF, wRow: {3'b111, 3'b111, 3'b111, 3'b111}, fB: 48'h0,
                  bnA: 16'h0100, bnB: 16'h0000,
                  exp0: {16'h7FFF, 16'h7FFF, 16'h7FFF}, exp1: {16'h7FFF, 16'h7FFF, 16'h7FFF}, exp2: 16'd0};
      vecs[4] = '{inData: 16'h7FFF, wRow: {3'b000, 3'b000, 3'b000, 3'b000}, fB: 48'h0,
                  bnA: 16'h0100, bnB: 16'h0000,
                  exp0: {16'h0000, 16'h0000, 16'h0000}, exp1: {16'h8000, 16'h8000, 16'h8000}, exp2: 16'd0};
      vecs[5] = '{inData: 16'h0000, wRow: {3'b000, 3'b000, 3'b000, 3'b000}, fB: 48'h000efff7fff4,
                  bnA: 16'h0100, bnB: 16'h0000,
                  exp0: {16'h0000, 16'h0000, 16'h000E}, exp1: {16'hFFF4, 16'hFFF7, 16'h000E}, exp2: 16'd2};
      vecs[6] = '{inData: 16'h0000, wRow: {3'b000, 3'b000, 3'b000, 3'b000}, fB: 48'h000500050005,
                  bnA: 16'h0100, bnB: 16'h0000,
                  exp0: {16'h0005, 16'h0005, 16'h0005}, exp1: {16'h0005, 16'h0005, 16'h0005}, exp2: 16'd0};
      vecs[7] = '{inData: 16'h0100, wRow: {3'b110, 3'b110, 3'b110, 3'b110}, fB: 48'h0,
                  bnA: 16'h0100, bnB: 16'h0000,
                  exp0: {16'h0000, 16'h0400, 16'h0400}, exp1: {16'hFC00, 16'h0400, 16'h0400}, exp2: 16'd1};
      vecs[8] = '{inData: 16'h0001, wRow: {3'b111, 3'b111, 3'b111, 3'b111}, fB: 48'h0,
                  bnA: 16'hFFFF, bnB: 16'h0000,
                  exp0: {16'h0000, 16'h0000, 16'h0000}, exp1: {16'hFFFF, 16'hFFFF, 16'hFFFF}, exp2: 16'd0};
      vecs[9] = vecs[0];

      rst_n       = 1'b0;
      inValid     = 1'b0;
      inData      = '0;
      wRow        = '0;
      fB          = '0;
      bnA         = 16'sh0100;
      bnB         = '0;
      outReady[0] = 1'b1;
      outReady[1] = 1'b1;
      outReady[2] = 1'b1;
      repeat (2) @(negedge clk);

      for (int m = 0; m < 3; m++) begin
         checkOutput($sformatf("reset m%0d in_ready", m), inReady[m], 1);
         checkOutput($sformatf("reset m%0d out_valid", m), outValid[m], 0);
         checkOutput($sformatf("reset m%0d out_last", m), outLast[m], 0);
         checkOutput($sformatf("reset m%0d out_data", m), outData[m], 0);
         checkOutput($sformatf("reset m%0d w_addr", m), wAddr[m], 0);
         checkOutput($sformatf("reset m%0d bn_addr", m), bnAddr[m], 0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         applyStimulus(i, vecs[i]);
         collectFrame(i, vecs[i], 0);
      end

      $display("[TB] backpressure with in_valid held during drain");
      applyStimulus(50, vecs[0]);
      collectFrame(50, vecs[0], 3);

      $display("[TB] reset after two beats of a frame");
      for (int b = 0; b < 2; b++) begin
         inValid = 1'b1;
         inData  = 16'sh7FFF;
         wRow    = 3'b111;
         @(negedge clk);
      end
      inValid = 1'b0;
      checkOutput("partial frame w_addr", wAddr[1], 2);
      rst_n = 1'b0;
      #1;
      checkOutput("mid-frame reset w_addr", wAddr[1], 0);
      checkOutput("mid-frame reset in_ready", {inReady[2], inReady[1], inReady[0]}, 3'b111);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(60, vecs[0]);
      collectFrame(60, vecs[0], 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule
